// File: rtl/hbm_rd_req.sv
// Issues AXI3 read bursts for the B region then the A region; first ARVALID one cycle after start.
// ARVALID holds its payload until ARREADY; issue stalls while MAX_OUTSTANDING bursts await RLAST.
module hbm_rd_req #(
    parameter int                  ADDR_WIDTH      = 33,
    parameter int                  ID_WIDTH        = 6,
    parameter logic [ID_WIDTH-1:0] TAG_A           = ID_WIDTH'(1),
    parameter logic [ID_WIDTH-1:0] TAG_B           = ID_WIDTH'(2),
    parameter int                  MAX_BURST       = 16,
    parameter int                  MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base_addr,
    input  logic [ADDR_WIDTH-1:0] b_base_addr,
    input  logic [31:0]           data_length,
    input  logic [31:0]           b_length,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [3:0]            m_axi_ARLEN,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    input  logic                  m_axi_RVALID,
    input  logic                  m_axi_RREADY,
    input  logic                  m_axi_RLAST,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           req_counter,
    output logic [3:0]            outstanding
);
    typedef enum logic [2:0] {IDLE, REQ_B, REQ_A, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [26:0]           cur_rem;
    logic [26:0]           a_rem;
    logic [26:0]           a_beats;
    logic [26:0]           b_beats;
    logic                  hs;
    logic                  rl;
    logic                  can_issue;
    logic [3:0]            out_next;
    logic [4:0]            cur_burst;
    logic [26:0]           rem_after;
    logic [ADDR_WIDTH-1:0] addr_after;
    logic                  len_unused;

    // Bytes below one 32 B beat are dropped.
    assign a_beats    = data_length[31:5];
    assign b_beats    = b_length[31:5];
    assign len_unused = ^{data_length[4:0], b_length[4:0]};

    assign m_axi_ARSIZE  = 3'b101;
    assign m_axi_ARBURST = 2'b01;

    function automatic logic [3:0] arlen_for(input logic [26:0] rem);
        logic [4:0] beats;
        beats = (rem > 27'(MAX_BURST)) ? 5'(MAX_BURST) : rem[4:0];
        return 4'(beats - 5'd1);
    endfunction

    always_comb begin
        hs         = m_axi_ARVALID & m_axi_ARREADY;
        // A stray RLAST with nothing in flight is ignored.
        rl         = m_axi_RVALID & m_axi_RREADY & m_axi_RLAST & (outstanding != 4'd0);
        out_next   = outstanding + {3'd0, hs} - {3'd0, rl};
        can_issue  = out_next < 4'(MAX_OUTSTANDING);
        cur_burst  = {1'b0, m_axi_ARLEN} + 5'd1;
        rem_after  = hs ? cur_rem - 27'(cur_burst) : cur_rem;
        addr_after = hs ? cur_addr + ADDR_WIDTH'({cur_burst, 5'b0}) : cur_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_ARVALID <= 1'b0;
            m_axi_ARADDR  <= '0;
            m_axi_ARID    <= '0;
            m_axi_ARLEN   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            req_counter   <= '0;
            outstanding   <= '0;
            cur_addr      <= '0;
            cur_rem       <= '0;
            a_addr        <= '0;
            a_rem         <= '0;
        end else begin
            outstanding <= out_next;
            if (hs) begin
                req_counter <= req_counter + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        a_addr      <= a_base_addr;
                        a_rem       <= a_beats;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        req_counter <= '0;
                        if (b_beats != 27'd0) begin
                            state         <= REQ_B;
                            cur_addr      <= b_base_addr;
                            cur_rem       <= b_beats;
                            m_axi_ARVALID <= can_issue;
                            m_axi_ARADDR  <= b_base_addr;
                            m_axi_ARID    <= TAG_B;
                            m_axi_ARLEN   <= arlen_for(b_beats);
                        end else if (a_beats != 27'd0) begin
                            state         <= REQ_A;
                            cur_addr      <= a_base_addr;
                            cur_rem       <= a_beats;
                            m_axi_ARVALID <= can_issue;
                            m_axi_ARADDR  <= a_base_addr;
                            m_axi_ARID    <= TAG_A;
                            m_axi_ARLEN   <= arlen_for(a_beats);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ_B, REQ_A: begin
                    // A presented burst is frozen until accepted.
                    if (!m_axi_ARVALID || m_axi_ARREADY) begin
                        if (rem_after != 27'd0) begin
                            cur_addr      <= addr_after;
                            cur_rem       <= rem_after;
                            m_axi_ARVALID <= can_issue;
                            m_axi_ARADDR  <= addr_after;
                            m_axi_ARLEN   <= arlen_for(rem_after);
                        end else if (state == REQ_B && a_rem != 27'd0) begin
                            state         <= REQ_A;
                            cur_addr      <= a_addr;
                            cur_rem       <= a_rem;
                            m_axi_ARVALID <= can_issue;
                            m_axi_ARADDR  <= a_addr;
                            m_axi_ARID    <= TAG_A;
                            m_axi_ARLEN   <= arlen_for(a_rem);
                        end else begin
                            state         <= DRAIN;
                            cur_rem       <= '0;
                            m_axi_ARVALID <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == 4'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hbm_rd_req.sv
// Randomized bench for hbm_rd_req: expected AR sequence built from region lengths, in-flight count tracked per cycle.
module tb_hbm_rd_req;
    localparam int         AW    = 33;
    localparam int         MAXO  = 8;
    localparam logic [5:0] TAG_A = 6'd1;
    localparam logic [5:0] TAG_B = 6'd2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [5:0]    id;
    } ar_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          fresh = 1'b0;
    logic [AW-1:0] a_base = '0;
    logic [AW-1:0] b_base = '0;
    logic [31:0]   data_length = '0;
    logic [31:0]   b_length = '0;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [5:0]    arid;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          rvalid = 1'b0;
    logic          rready = 1'b0;
    logic          rlast = 1'b0;
    logic          busy;
    logic          done;
    logic [31:0]   req_counter;
    logic [3:0]    outstanding;

    ar_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  m_out = 0;
    int  m_reqs = 0;
    int  resp_mode = 0;
    int  force_req = 0;
    int  force_done = 0;

    hbm_rd_req dut (
        .clk(clk), .rst(rst), .start(start),
        .a_base_addr(a_base), .b_base_addr(b_base),
        .data_length(data_length), .b_length(b_length),
        .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr),
        .m_axi_ARID(arid), .m_axi_ARLEN(arlen), .m_axi_ARSIZE(arsize), .m_axi_ARBURST(arburst),
        .m_axi_RVALID(rvalid), .m_axi_RREADY(rready), .m_axi_RLAST(rlast),
        .busy(busy), .done(done), .req_counter(req_counter), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected bursts for one region: chop into at most 16 beats, 32 B per beat.
    function automatic void add_region(input logic [AW-1:0] base, input logic [31:0] bytes, input logic [5:0] id);
        longint        rem;
        longint        l;
        logic [AW-1:0] addr;
        ar_t           a;
        rem  = longint'(bytes) / 32;
        addr = base;
        while (rem > 0) begin
            l      = (rem > 16) ? 16 : rem;
            a.addr = addr;
            a.len  = 4'(l - 1);
            a.id   = id;
            exp_q.push_back(a);
            addr   = addr + AW'(l * 32);
            rem    = rem - l;
        end
    endfunction

    function automatic void build(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                  input logic [31:0] dl, input logic [31:0] bl);
        add_region(bb, bl, TAG_B);
        add_region(ab, dl, TAG_A);
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Per-cycle compare against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_arvalid", 64'(arvalid), 64'(0));
            chk("rst_outstanding", 64'(outstanding), 64'(0));
            chk("rst_req_counter", 64'(req_counter), 64'(0));
            exp_q.delete();
            m_out  = 0;
            m_reqs = 0;
        end else begin
            chk("outstanding", 64'(outstanding), 64'(m_out));
            chk("req_counter", 64'(req_counter), 64'(m_reqs));
            chk("arsize_arburst", 64'({arsize, arburst}), 64'({3'b101, 2'b01}));
            if (arvalid) begin
                chk("ar_expected_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    chk("ar_addr", 64'(araddr), 64'(exp_q[0].addr));
                    chk("ar_len", 64'(arlen), 64'(exp_q[0].len));
                    chk("ar_id", 64'(arid), 64'(exp_q[0].id));
                end
                chk("ar_credit", 64'(m_out < MAXO), 64'(1));
            end
            if (start && fresh) m_reqs = 0;
            if (rvalid && rready && rlast && m_out > 0) m_out--;
            if (arvalid && arready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                m_reqs++;
                m_out++;
            end
        end
    end

    // Response snooper stimulus: completions only for bursts in flight, plus non-completing noise.
    initial begin
        int r;
        forever begin
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            rready = 1'b0;
            rlast  = 1'b0;
            r      = int'($urandom_range(0, 7));
            if (force_req > force_done) begin
                {rvalid, rready, rlast} = 3'b111;
                force_done++;
            end else if (resp_mode == 1) begin
                if (r < 3 && m_out > 0) {rvalid, rready, rlast} = 3'b111;
                else if (r == 3) {rvalid, rready, rlast} = 3'b101;
                else if (r == 4) {rvalid, rready, rlast} = 3'b110;
            end else if (resp_mode == 2) begin
                {rvalid, rready, rlast} = 3'b111;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        fresh = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fresh = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int ar_mode, input int dup_at, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
            arready = pick(ar_mode);
            start   = (n == dup_at);
        end
        start = 1'b0;
        chk({name, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic post_checks(input int n_exp, input string name);
        chk({name, "_busy_end"}, 64'(busy), 64'(0));
        chk({name, "_req_total"}, 64'(req_counter), 64'(n_exp));
        chk({name, "_all_issued"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [31:0] dl,
                       input logic [31:0] bl, input int ar_mode, input int budget, input int dup_at,
                       input string name);
        int n_exp;
        a_base      = ab;
        b_base      = bb;
        data_length = dl;
        b_length    = bl;
        build(ab, bb, dl, bl);
        n_exp = exp_q.size();
        pulse_start();
        arready = pick(ar_mode);
        @(negedge clk);
        chk({name, "_busy_start"}, 64'(busy), 64'(1));
        chk({name, "_done_cleared"}, 64'(done), 64'(0));
        wait_done(budget, ar_mode, dup_at, name);
        post_checks(n_exp, name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ab;
        logic [AW-1:0] bb;
        logic [31:0]   dl;
        logic [31:0]   bl;
        int            n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_payload", 64'({araddr, arid, arlen}), 64'(0));
        rst = 1'b0;
        resp_mode = 1;

        // Literal pins on the model itself, then the live runs.
        build(33'h2000, 33'h1000, 32'd1024, 32'd64);
        chk("pin1_count", 64'(exp_q.size()), 64'(3));
        chk("pin1_b", 64'({exp_q[0].addr, exp_q[0].id, exp_q[0].len}), 64'({33'h1000, 6'd2, 4'd1}));
        chk("pin1_a0", 64'({exp_q[1].addr, exp_q[1].id, exp_q[1].len}), 64'({33'h2000, 6'd1, 4'd15}));
        chk("pin1_a1", 64'({exp_q[2].addr, exp_q[2].id, exp_q[2].len}), 64'({33'h2200, 6'd1, 4'd15}));
        exp_q.delete();
        run(33'h2000, 33'h1000, 32'd1024, 32'd64, 1, 200, 0, "t1");

        build(33'h8000, 33'h5000, 32'd800, 32'd0);
        chk("pin2_count", 64'(exp_q.size()), 64'(2));
        chk("pin2_a0", 64'({exp_q[0].addr, exp_q[0].id, exp_q[0].len}), 64'({33'h8000, 6'd1, 4'd15}));
        chk("pin2_a1", 64'({exp_q[1].addr, exp_q[1].id, exp_q[1].len}), 64'({33'h8200, 6'd1, 4'd8}));
        exp_q.delete();
        run(33'h8000, 33'h5000, 32'd800, 32'd0, 2, 300, 0, "t2");

        // ARREADY withheld: payload must stay frozen for six cycles.
        a_base = 33'h4000; b_base = 33'h3000; data_length = 32'd0; b_length = 32'd32;
        build(a_base, b_base, data_length, b_length);
        arready = 1'b0;
        pulse_start();
        chk("hold_first_valid", 64'(arvalid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(arvalid), 64'(1));
            chk("hold_payload", 64'({araddr, arid, arlen}), 64'({33'h3000, 6'd2, 4'd0}));
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        wait_done(100, 0, 0, "hold");
        post_checks(1, "hold");

        // In-flight limit with responses withheld, then a single RLAST frees one credit.
        resp_mode = 0;
        a_base = 33'h1_0000_0000; b_base = 33'h0; data_length = 32'd8192; b_length = 32'd0;
        build(a_base, b_base, data_length, b_length);
        arready = 1'b1;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        chk("lim_reqs", 64'(req_counter), 64'(8));
        chk("lim_outstanding", 64'(outstanding), 64'(8));
        chk("lim_valid_low", 64'(arvalid), 64'(0));
        @(negedge clk);
        force_req++;
        @(posedge clk); #1;
        chk("lim_valid_pre", 64'(arvalid), 64'(0));
        @(posedge clk); #1;
        chk("lim_next_valid", 64'(arvalid), 64'(1));
        chk("lim_out_after", 64'(outstanding), 64'(7));
        resp_mode = 1;
        wait_done(1000, 1, 0, "lim");
        post_checks(16, "lim");

        run(33'h6000, 33'h7000, 32'd0, 32'd0, 1, 1, 0, "zero");
        run(33'h20000, 33'h30000, 32'd4096, 32'd1024, 2, 600, 3, "dup");

        // Stray RLASTs while idle must not underflow the count.
        resp_mode = 2;
        repeat (4) @(posedge clk);
        #1;
        resp_mode = 0;
        chk("stray_outstanding", 64'(outstanding), 64'(0));

        // Reset mid-run with three bursts in flight and a fourth presented.
        a_base = 33'h40000; b_base = 33'h0; data_length = 32'd4096; b_length = 32'd0;
        build(a_base, b_base, data_length, b_length);
        arready = 1'b1;
        pulse_start();
        n = 0;
        while (m_reqs < 3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        arready = 1'b0;
        chk("rst6_three_issued", 64'(m_reqs), 64'(3));
        @(posedge clk); #1;
        chk("rst6_pre_valid", 64'(arvalid), 64'(1));
        chk("rst6_pre_out", 64'(outstanding), 64'(3));
        rst = 1'b1;
        #1;
        chk("rst6_valid", 64'(arvalid), 64'(0));
        chk("rst6_out", 64'(outstanding), 64'(0));
        chk("rst6_busy", 64'(busy), 64'(0));
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_mode = 1;
        run(33'h50000, 33'h60000, 32'd1536, 32'd96, 2, 600, 0, "rst6_fresh");

        for (int k = 0; k < 8; k++) begin
            ab = AW'({$urandom(), $urandom()}) & ~AW'(511);
            bb = AW'({$urandom(), $urandom()}) & ~AW'(511);
            if ($urandom_range(0, 3) == 0) dl = 32'd0;
            else dl = 32'($urandom_range(0, 6000));
            if ($urandom_range(0, 3) == 0) bl = 32'd0;
            else bl = 32'($urandom_range(0, 3000));
            run(ab, bb, dl, bl, 2, 3000, 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hbm_rd_req.md
Name: hbm_rd_req

Overview:
Upstream read-request engine for the HBM read-response dispatcher. On start it issues AXI3 read bursts on one HBM pseudo-channel. It fetches the B (label) region first, tagged TAG_B, then the A (sample) region, tagged TAG_A. It bounds in-flight bursts by snooping RLAST on the response channel that the dispatcher consumes, and reports completion once all requested data has returned.

Parameters:
ADDR_WIDTH, 33, HBM byte address width
ID_WIDTH, 6, AXI ID width; must match the dispatcher
TAG_A, 6'd1, ARID for A-region bursts; equals the A read tag the dispatcher decodes
TAG_B, 6'd2, ARID for B-region bursts; equals the B read tag the dispatcher decodes
MAX_BURST, 16, max beats per burst (AXI3 limit); 32 B per beat
MAX_OUTSTANDING, 8, max bursts issued but not yet completed by RLAST

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
a_base_addr  in  ADDR_WIDTH  A region start address; 512 B aligned
b_base_addr  in  ADDR_WIDTH  B region start address; 512 B aligned
data_length  in  32  A region length in bytes; beats = data_length>>5
b_length  in  32  B region length in bytes; beats = b_length>>5
m_axi_ARVALID  out  1  read address valid
m_axi_ARREADY  in  1  read address ready
m_axi_ARADDR  out  ADDR_WIDTH  burst start address
m_axi_ARID  out  ID_WIDTH  TAG_A or TAG_B
m_axi_ARLEN  out  4  beats-1
m_axi_ARSIZE  out  3  constant 3'b101
m_axi_ARBURST  out  2  constant 2'b01 (INCR)
m_axi_RVALID  in  1  snooped response valid
m_axi_RREADY  in  1  snooped response ready (driven by dispatcher)
m_axi_RLAST  in  1  snooped response last
busy  out  1  high from the cycle after an accepted start until done
done  out  1  level; set on completion, cleared by next accepted start
req_counter  out  32  AR handshakes since last start
outstanding  out  4  current in-flight burst count

Behaviour:
- Reset (asynchronous, immediate): state IDLE; ARVALID=0, ARADDR/ARID/ARLEN=0, busy=0, done=0, req_counter=0, outstanding=0, beat counters=0. Reset mid-burst abandons the run and drops ARVALID at once. This is accepted only under a global reset that also resets the HBM controller.
- FSM states: IDLE, REQ_B, REQ_A, DRAIN, DONE.
- IDLE: on start, latch addresses and beat counts (lengths >>5, remainder bytes ignored), clear done/req_counter, set busy.
  - Next state is REQ_B if B beats>0, else REQ_A if A beats>0, else DONE.
  - start in any other state is ignored.
- REQ_x: next burst length L = min(remaining, MAX_BURST); ARLEN=L-1; ARADDR=current address; ARID=TAG_x.
  - ARVALID asserts only when outstanding < MAX_OUTSTANDING. First ARVALID is the cycle after start (latency 1).
  - Once asserted, ARVALID and the full payload stay stable until ARREADY; no withdrawal.
  - On handshake: address += L*32, remaining -= L, req_counter++, outstanding++.
  - Back-to-back issue is allowed: the next burst's ARVALID may be high the cycle after a handshake.
  - When remaining reaches 0: REQ_B goes to REQ_A (or DRAIN if A beats=0); REQ_A goes to DRAIN.
- Outstanding tracking: decrement on RVALID & RREADY & RLAST. Simultaneous AR handshake and RLAST leaves it unchanged. Never exceeds MAX_OUTSTANDING; never underflows (a stray RLAST at 0 is ignored).
- DRAIN: wait for outstanding==0, then DONE.
- DONE: done=1, busy=0, return to IDLE in the same cycle. done stays high until the next start.
- Alignment: 512 B-aligned bases with MAX_BURST=16 guarantee no 4 KB crossing. Unaligned bases are unsupported; the block does not check them.
- ARSIZE/ARBURST are constants in all states, including reset.

Test Plan:
1. b_length=64, data_length=1024, b_base=0x1000, a_base=0x2000, ARREADY=1, responses returned → ARs in order:
   - (0x1000, len 1, TAG_B)
   - (0x2000, len 15, TAG_A)
   - (0x2200, len 15, TAG_A)
   - After 3 RLASTs: done=1, req_counter=3.
2. b_length=0, data_length=800 (25 beats) → two ARs: (a_base, len 15) and (a_base+0x200, len 8); no TAG_B request.
3. ARREADY held low 5 cycles after first ARVALID → ARVALID, ARADDR, ARID and ARLEN are constant for all 6 cycles; exactly one handshake.
4. MAX_OUTSTANDING=2, data_length=2048, no R beats → exactly 2 ARs and outstanding=2. One RLAST → third AR issued on the following cycle.
5. Both lengths 0, start → no ARVALID, done=1 within 2 cycles. A second start during busy in another run is ignored (req_counter unaffected).
6. Assert rst while ARVALID=1 and outstanding=3 → ARVALID=0 and outstanding=0 immediately. A later start runs a fresh sequence from the new bases.
